// File: rtl/hazard_ctrl_if.sv
// Decode-to-controller bundle: decode-stage operand/destination info in,
// pipeline-register control strobes out.
interface hazard_ctrl_if;
  logic       id_valid;
  logic [2:0] id_rs;
  logic       id_rs_used;
  logic [2:0] id_rt;
  logic       id_rt_used;
  logic       id_dec_use;
  logic [2:0] id_writereg;
  logic       id_regWrite;
  logic       id_memRead;
  logic       id_halt;
  logic       id_flush;
  logic       dmem_stall;

  logic       stall;
  logic       bubble;
  logic       flush;
  logic       freeze;
  logic       halt_done;

  // Pipeline side: drives the decode view, consumes the control strobes.
  modport master (
    output id_valid, id_rs, id_rs_used, id_rt, id_rt_used, id_dec_use,
    output id_writereg, id_regWrite, id_memRead, id_halt, id_flush,
    output dmem_stall,
    input  stall, bubble, flush, freeze, halt_done
  );

  // Controller side.
  modport slave (
    input  id_valid, id_rs, id_rs_used, id_rt, id_rt_used, id_dec_use,
    input  id_writereg, id_regWrite, id_memRead, id_halt, id_flush,
    input  dmem_stall,
    output stall, bubble, flush, freeze, halt_done
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage core: scoreboards in-flight
// destinations, raises stall/bubble/flush/freeze, and drains the pipe on halt.
module hazard_ctrl #(
  parameter int FWD          = 0,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic          clk,
  input  logic          rst,
  hazard_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    HALTED = 2'd2
  } state_t;

  typedef struct packed {
    logic       v;
    logic [2:0] dest;
    logic       ld;
  } sbEntry_t;

  localparam int CntW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DRAIN_CYCLES - 1);

  state_t          state, stateNext;
  logic [CntW-1:0] cnt, cntNext;
  sbEntry_t        sbEx, sbMem, sbExNext;

  logic running;
  logic frozen;
  logic matchEx, matchMem, dmatchEx, dmatchMem;
  logic hazardRaw, hazard;

  assign running = (state == RUN);
  assign frozen  = bus.dmem_stall;

  // WB results reach decode through the register-file write-through bypass,
  // so only EX and MEM producers can ever cause a hazard.
  always_comb begin
    matchEx   = sbEx.v  & ((bus.id_rs_used & (bus.id_rs == sbEx.dest)) |
                           (bus.id_rt_used & (bus.id_rt == sbEx.dest)));
    matchMem  = sbMem.v & ((bus.id_rs_used & (bus.id_rs == sbMem.dest)) |
                           (bus.id_rt_used & (bus.id_rt == sbMem.dest)));
    dmatchEx  = sbEx.v  & bus.id_dec_use & bus.id_rs_used & (bus.id_rs == sbEx.dest);
    dmatchMem = sbMem.v & bus.id_dec_use & bus.id_rs_used & (bus.id_rs == sbMem.dest);

    if (FWD == 0) begin
      hazardRaw = matchEx | matchMem;
    end else begin
      hazardRaw = (matchEx & sbEx.ld) | dmatchEx | (dmatchMem & sbMem.ld);
    end

    hazard = bus.id_valid & running & hazardRaw;
  end

  // Priority freeze > hazard > flush; everything is forced low during reset.
  always_comb begin
    bus.freeze    = ~rst & frozen;
    bus.stall     = ~rst & ~frozen & (hazard | ~running);
    bus.bubble    = ~rst & ~frozen & hazard;
    bus.flush     = ~rst & ~frozen & ~hazard & bus.id_valid & bus.id_flush & running;
    bus.halt_done = ~rst & (state == HALTED);
  end

  // Next-state: halt is accepted only once its own operands are clean; the
  // drain counter then runs on non-frozen edges until the pipe is empty.
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    sbExNext  = '0;

    case (state)
      RUN: begin
        if (bus.id_valid & bus.id_halt & ~hazard) begin
          stateNext = DRAIN;
          cntNext   = '0;
        end
      end
      DRAIN: begin
        cntNext = cnt + 1'b1;
        if (cnt == CntLast) begin
          stateNext = HALTED;
        end
      end
      HALTED: begin
        stateNext = HALTED;
      end
      default: begin
        stateNext = RUN;
      end
    endcase

    if (bus.id_valid & bus.id_regWrite & ~hazard & running) begin
      sbExNext.v    = 1'b1;
      sbExNext.dest = bus.id_writereg;
      sbExNext.ld   = bus.id_memRead;
    end
  end

  // A frozen cycle holds the scoreboard and the FSM exactly as they are.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      cnt   <= '0;
      sbEx  <= '0;
      sbMem <= '0;
    end else if (!frozen) begin
      state <= stateNext;
      cnt   <= cntNext;
      sbMem <= sbEx;
      sbEx  <= sbExNext;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: one DUT without forwarding, one with,
// both fed the same decode stream; outputs compared as {stall,bubble,flush,freeze,halt_done}.
module tb_hazard_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       idValid, idRsUsed, idRtUsed, idDecUse, idRegWrite, idMemRead, idHalt, idFlush;
  logic [2:0] idRs, idRt, idWritereg;
  logic       dmemStall;

  int checkCount = 0;
  int failCount  = 0;

  hazard_ctrl_if if0 ();
  hazard_ctrl_if if1 ();

  assign if0.id_valid = idValid;      assign if1.id_valid = idValid;
  assign if0.id_rs = idRs;            assign if1.id_rs = idRs;
  assign if0.id_rs_used = idRsUsed;   assign if1.id_rs_used = idRsUsed;
  assign if0.id_rt = idRt;            assign if1.id_rt = idRt;
  assign if0.id_rt_used = idRtUsed;   assign if1.id_rt_used = idRtUsed;
  assign if0.id_dec_use = idDecUse;   assign if1.id_dec_use = idDecUse;
  assign if0.id_writereg = idWritereg; assign if1.id_writereg = idWritereg;
  assign if0.id_regWrite = idRegWrite; assign if1.id_regWrite = idRegWrite;
  assign if0.id_memRead = idMemRead;  assign if1.id_memRead = idMemRead;
  assign if0.id_halt = idHalt;        assign if1.id_halt = idHalt;
  assign if0.id_flush = idFlush;      assign if1.id_flush = idFlush;
  assign if0.dmem_stall = dmemStall;  assign if1.dmem_stall = dmemStall;

  hazard_ctrl #(.FWD(0), .DRAIN_CYCLES(3)) u0 (.clk(clk), .rst(rst), .bus(if0));
  hazard_ctrl #(.FWD(1), .DRAIN_CYCLES(3)) u1 (.clk(clk), .rst(rst), .bus(if1));

  logic [4:0] out0, out1;
  assign out0 = {if0.stall, if0.bubble, if0.flush, if0.freeze, if0.halt_done};
  assign out1 = {if1.stall, if1.bubble, if1.flush, if1.freeze, if1.halt_done};

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [2:0] rs, input logic rsU,
                               input logic [2:0] rt, input logic rtU, input logic decU,
                               input logic [2:0] wr, input logic rw, input logic mr,
                               input logic hl, input logic fl);
    idValid = v;  idRs = rs;  idRsUsed = rsU;  idRt = rt;  idRtUsed = rtU;
    idDecUse = decU;  idWritereg = wr;  idRegWrite = rw;  idMemRead = mr;
    idHalt = hl;  idFlush = fl;
    #1;
  endtask

  task automatic nop();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic resetDuts();
    rst = 1'b1;
    dmemStall = 1'b0;
    nop();
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    dmemStall = 1'b1;
    applyStimulus(1, 3, 1, 3, 1, 1, 3, 1, 1, 1, 1);
    checkCount++;
    if (out0 !== 5'b00000) begin failCount++; $display("FAIL reset_comb_fwd0: got %b expected %b", out0, 5'b00000); end
    checkCount++;
    if (out1 !== 5'b00000) begin failCount++; $display("FAIL reset_comb_fwd1: got %b expected %b", out1, 5'b00000); end
    tick();
    checkCount++;
    if (out0 !== 5'b00000) begin failCount++; $display("FAIL reset_edge_fwd0: got %b expected %b", out0, 5'b00000); end
    dmemStall = 1'b0;
  endtask

  task automatic test_raw_fwd0();
    resetDuts();
    applyStimulus(1, 0, 0, 0, 0, 0, 3, 1, 0, 0, 0);
    checkCount++;
    if (out0 !== 5'b00000) begin failCount++; $display("FAIL raw_producer: got %b expected %b", out0, 5'b00000); end
    tick();
    applyStimulus(1, 3, 1, 2, 1, 0, 1, 1, 0, 0, 0);
    checkCount++;
    if (out0 !== 5'b11000) begin failCount++; $display("FAIL raw_ex_fwd0: got %b expected %b", out0, 5'b11000); end
    checkCount++;
    if (out1 !== 5'b00000) begin failCount++; $display("FAIL raw_ex_fwd1: got %b expected %b", out1, 5'b00000); end
    tick();
    checkCount++;
    if (out0 !== 5'b11000) begin failCount++; $display("FAIL raw_mem_fwd0: got %b expected %b", out0, 5'b11000); end
    tick();
    checkCount++;
    if (out0 !== 5'b00000) begin failCount++; $display("FAIL raw_clear_fwd0: got %b expected %b", out0, 5'b00000); end
  endtask

  task automatic test_reg7_used();
    resetDuts();
    applyStimulus(1, 0, 0, 0, 0, 0, 7, 1, 0, 0, 0);
    tick();
    applyStimulus(1, 7, 0, 7, 0, 0, 2, 0, 0, 0, 0);
    checkCount++;
    if (out0 !== 5'b00000) begin failCount++; $display("FAIL reg7_unused: got %b expected %b", out0, 5'b00000); end
    applyStimulus(1, 7, 0, 7, 1, 0, 2, 0, 0, 0, 0);
    checkCount++;
    if (out0 !== 5'b11000) begin failCount++; $display("FAIL reg7_rt_used: got %b expected %b", out0, 5'b11000); end
  endtask

  task automatic test_load_fwd1();
    resetDuts();
    applyStimulus(1, 0, 0, 0, 0, 0, 4, 1, 1, 0, 0);
    tick();
    applyStimulus(1, 4, 1, 4, 1, 0, 5, 1, 0, 0, 0);
    checkCount++;
    if (out1 !== 5'b11000) begin failCount++; $display("FAIL load_use_c1: got %b expected %b", out1, 5'b11000); end
    tick();
    checkCount++;
    if (out1 !== 5'b00000) begin failCount++; $display("FAIL load_use_c2: got %b expected %b", out1, 5'b00000); end
    tick();
    checkCount++;
    if (out1 !== 5'b00000) begin failCount++; $display("FAIL load_use_c3: got %b expected %b", out1, 5'b00000); end
    resetDuts();
    applyStimulus(1, 0, 0, 0, 0, 0, 4, 1, 0, 0, 0);
    tick();
    applyStimulus(1, 4, 1, 4, 1, 0, 5, 1, 0, 0, 0);
    checkCount++;
    if (out1 !== 5'b00000) begin failCount++; $display("FAIL alu_use_fwd1: got %b expected %b", out1, 5'b00000); end
    checkCount++;
    if (out0 !== 5'b11000) begin failCount++; $display("FAIL alu_use_fwd0: got %b expected %b", out0, 5'b11000); end
  endtask

  task automatic test_branch_fwd1();
    resetDuts();
    applyStimulus(1, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0);
    tick();
    applyStimulus(1, 2, 1, 0, 0, 1, 0, 0, 0, 0, 1);
    checkCount++;
    if (out1 !== 5'b11000) begin failCount++; $display("FAIL branch_stall: got %b expected %b", out1, 5'b11000); end
    tick();
    checkCount++;
    if (out1 !== 5'b00100) begin failCount++; $display("FAIL branch_flush: got %b expected %b", out1, 5'b00100); end
    tick();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkCount++;
    if (out1 !== 5'b00000) begin failCount++; $display("FAIL branch_after: got %b expected %b", out1, 5'b00000); end
    resetDuts();
    applyStimulus(1, 0, 0, 0, 0, 0, 2, 1, 1, 0, 0);
    tick();
    applyStimulus(1, 2, 1, 0, 0, 1, 0, 0, 0, 0, 1);
    checkCount++;
    if (out1 !== 5'b11000) begin failCount++; $display("FAIL ldbr_ex: got %b expected %b", out1, 5'b11000); end
    tick();
    checkCount++;
    if (out1 !== 5'b11000) begin failCount++; $display("FAIL ldbr_mem: got %b expected %b", out1, 5'b11000); end
    tick();
    checkCount++;
    if (out1 !== 5'b00100) begin failCount++; $display("FAIL ldbr_go: got %b expected %b", out1, 5'b00100); end
  endtask

  task automatic test_freeze();
    resetDuts();
    applyStimulus(1, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0);
    tick();
    nop();
    tick();
    dmemStall = 1'b1;
    applyStimulus(1, 1, 1, 1, 1, 0, 2, 1, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      checkCount++;
      if (out0 !== 5'b00010) begin failCount++; $display("FAIL freeze_fwd0_c%0d: got %b expected %b", i, out0, 5'b00010); end
      checkCount++;
      if (out1 !== 5'b00010) begin failCount++; $display("FAIL freeze_fwd1_c%0d: got %b expected %b", i, out1, 5'b00010); end
      tick();
    end
    dmemStall = 1'b0;
    #1;
    checkCount++;
    if (out0 !== 5'b11000) begin failCount++; $display("FAIL unfreeze_fwd0: got %b expected %b", out0, 5'b11000); end
    checkCount++;
    if (out1 !== 5'b00100) begin failCount++; $display("FAIL unfreeze_fwd1: got %b expected %b", out1, 5'b00100); end
  endtask

  task automatic test_halt();
    resetDuts();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    checkCount++;
    if (out0 !== 5'b00100) begin failCount++; $display("FAIL halt_accept: got %b expected %b", out0, 5'b00100); end
    tick();
    nop();
    checkCount++;
    if (out0 !== 5'b10000) begin failCount++; $display("FAIL drain_0: got %b expected %b", out0, 5'b10000); end
    tick();
    checkCount++;
    if (out0 !== 5'b10000) begin failCount++; $display("FAIL drain_1: got %b expected %b", out0, 5'b10000); end
    dmemStall = 1'b1;
    #1;
    checkCount++;
    if (out0 !== 5'b00010) begin failCount++; $display("FAIL drain_frozen: got %b expected %b", out0, 5'b00010); end
    tick();
    tick();
    dmemStall = 1'b0;
    #1;
    checkCount++;
    if (out0 !== 5'b10000) begin failCount++; $display("FAIL drain_resume: got %b expected %b", out0, 5'b10000); end
    tick();
    checkCount++;
    if (out0 !== 5'b10000) begin failCount++; $display("FAIL drain_2: got %b expected %b", out0, 5'b10000); end
    tick();
    checkCount++;
    if (out0 !== 5'b10001) begin failCount++; $display("FAIL halted_fwd0: got %b expected %b", out0, 5'b10001); end
    checkCount++;
    if (out1 !== 5'b10001) begin failCount++; $display("FAIL halted_fwd1: got %b expected %b", out1, 5'b10001); end
    tick();
    tick();
    checkCount++;
    if (out0 !== 5'b10001) begin failCount++; $display("FAIL halted_stays: got %b expected %b", out0, 5'b10001); end
  endtask

  task automatic test_reset_halted();
    rst = 1'b1;
    #1;
    checkCount++;
    if (out0 !== 5'b00000) begin failCount++; $display("FAIL rst_halted_comb: got %b expected %b", out0, 5'b00000); end
    tick();
    checkCount++;
    if (out0 !== 5'b00000) begin failCount++; $display("FAIL rst_halted_edge: got %b expected %b", out0, 5'b00000); end
    rst = 1'b0;
    nop();
    checkCount++;
    if (out0 !== 5'b00000) begin failCount++; $display("FAIL post_rst_run: got %b expected %b", out0, 5'b00000); end
    applyStimulus(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0);
    tick();
    applyStimulus(1, 1, 1, 1, 1, 0, 2, 1, 0, 0, 0);
    checkCount++;
    if (out0 !== 5'b11000) begin failCount++; $display("FAIL post_rst_raw: got %b expected %b", out0, 5'b11000); end
  endtask

  initial begin
    rst = 1'b1;
    dmemStall = 1'b0;
    nop();
    $display("[TB] starting hazard_ctrl directed tests");
    test_reset();
    test_raw_fwd0();
    test_reg7_used();
    test_load_fwd1();
    test_branch_fwd1();
    test_freeze();
    test_halt();
    test_reset_halted();
    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
